// File: rtl/key_latch8.sv
`default_nettype none
// ============================================================================
// Module      : key_latch8
// Description : Eight-channel key front end for an 8-3 priority encoder.
//               Each raw key line is synchronised, debounced and
//               edge-detected. Every debounced press is latched until the
//               consumer clears it, so a short press cannot slip between
//               encoder samples. The latched set is presented active-low,
//               in the encoder's input format, with an active-low enable.
//
// Ports       : iClk    - clock, rising edge
//               iRst_n  - asynchronous active-low reset
//               iKey    - raw key lines, active-high, asynchronous to iClk
//               iClr    - synchronous clear of all latched presses
//               oData   - latched presses, active-low (0 = key latched)
//               oValid  - high while any key is latched
//               oEI     - active-low encoder enable (~oValid)
//
// Parameters  : DEBOUNCE_CYCLES - number of consecutive cycles the
//               synchronised input must differ from the debounced state
//               before that state follows it (legal range 2..255)
//
// Revision    : 1.0 - initial release
// ============================================================================
module key_latch8 #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic       iClk,
    input  logic       iRst_n,
    input  logic [7:0] iKey,
    input  logic       iClr,
    output logic [7:0] oData,
    output logic       oValid,
    output logic       oEI
);

    // Terminal count of the per-channel debounce counter.
    localparam logic [7:0] c_CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

    logic [7:0] r_s1;       // first synchroniser stage
    logic [7:0] r_s2;       // second synchroniser stage
    logic [7:0] r_deb;      // debounced key state
    logic [7:0] r_deb_d;    // debounced state delayed one cycle
    logic [7:0] r_lat;      // latched presses, active-high
    logic [7:0] w_rise;     // debounced rising edge per channel

    // ------------------------------------------------------------------------
    // Two-flop synchroniser for the asynchronous key lines.
    // ------------------------------------------------------------------------
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_s1 <= 8'h00;
            r_s2 <= 8'h00;
        end else begin
            r_s1 <= iKey;
            r_s2 <= r_s1;
        end
    end

    // ------------------------------------------------------------------------
    // Per-channel debounce. The counter only advances while the synchronised
    // input disagrees with the debounced state; any agreeing cycle restarts
    // it, so isolated bounces never accumulate towards a transition.
    // ------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_ch
            logic [7:0] r_cnt;

            always_ff @(posedge iClk or negedge iRst_n) begin
                if (!iRst_n) begin
                    r_cnt     <= 8'h00;
                    r_deb[gi] <= 1'b0;
                end else if (r_s2[gi] == r_deb[gi]) begin
                    r_cnt     <= 8'h00;
                end else if (r_cnt >= c_CNT_LAST) begin
                    // Disagreement has persisted long enough: accept it.
                    r_deb[gi] <= r_s2[gi];
                    r_cnt     <= 8'h00;
                end else begin
                    r_cnt     <= r_cnt + 8'h01;
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Edge detect and press latch. A rise takes precedence over a clear on
    // the same edge so a press arriving during a clear is not lost. A key
    // held through a clear produces no new rise, so it stays cleared until
    // it is released and pressed again.
    // ------------------------------------------------------------------------
    assign w_rise = r_deb & ~r_deb_d;

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_deb_d <= 8'h00;
            r_lat   <= 8'h00;
        end else begin
            r_deb_d <= r_deb;
            r_lat   <= w_rise | (iClr ? 8'h00 : r_lat);
        end
    end

    // ------------------------------------------------------------------------
    // Encoder-facing outputs, purely from the latch register.
    // ------------------------------------------------------------------------
    assign oData  = ~r_lat;
    assign oValid = |r_lat;
    assign oEI    = ~oValid;

endmodule
`default_nettype wire

// File: tb/tb_key_latch8.sv
`default_nettype none
// ============================================================================
// Module      : tb_key_latch8
// Description : Self-checking bench for key_latch8 (DEBOUNCE_CYCLES = 4).
//               Table-driven vectors of {key, clear, expected oData} plus
//               hand-written reset sequences. Expected values are queued
//               when stimulus is driven and popped when the output is sampled.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_key_latch8;

    logic       iClk;
    logic       iRst_n;
    logic [7:0] iKey;
    logic       iClr;
    logic [7:0] oData;
    logic       oValid;
    logic       oEI;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] key;
        logic       clr;
        logic [7:0] exp;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] exp_q[$];

    key_latch8 #(.DEBOUNCE_CYCLES(4)) dut (
        .iClk   (iClk),
        .iRst_n (iRst_n),
        .iKey   (iKey),
        .iClr   (iClr),
        .oData  (oData),
        .oValid (oValid),
        .oEI    (oEI)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    task automatic check(input string nm, input logic [7:0] exp);
        logic exp_v;
        exp_v = (exp != 8'hFF);
        checks++;
        if (oData !== exp) begin
            errors++;
            $display("FAIL %s oData got %h want %h at %0t", nm, oData, exp, $time);
        end
        checks++;
        if (oValid !== exp_v) begin
            errors++;
            $display("FAIL %s oValid got %b want %b at %0t", nm, oValid, exp_v, $time);
        end
        checks++;
        if (oEI !== ~exp_v) begin
            errors++;
            $display("FAIL %s oEI got %b want %b at %0t", nm, oEI, ~exp_v, $time);
        end
    endtask

    // Drive inputs now (away from the edge), queue the expectation for the
    // next rising edge, then sample 1 time unit after that edge.
    task automatic cyc(input logic [7:0] k, input logic c, input logic [7:0] e,
                       input string nm);
        iKey = k;
        iClr = c;
        exp_q.push_back(e);
        @(posedge iClk);
        #1;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s scoreboard empty", nm);
        end else begin
            check(nm, exp_q.pop_front());
        end
    endtask

    task automatic add(input logic [7:0] k, input logic c, input logic [7:0] e,
                       input int n);
        vec_t v;
        v.key = k;
        v.clr = c;
        v.exp = e;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    initial begin
        // ---------------- vector table (starts from idle, nothing latched)
        // Single press of key 3: latched exactly at edge 7, survives release.
        add(8'h08, 1'b0, 8'hFF, 6);
        add(8'h08, 1'b0, 8'hF7, 1);
        add(8'h00, 1'b0, 8'hF7, 8);
        add(8'h00, 1'b1, 8'hFF, 1);
        add(8'h00, 1'b0, 8'hFF, 2);
        // Bounce on key 2: 1,0,1,1,0 then held; s2 settles high after edge 7,
        // latch after edge 12.
        add(8'h04, 1'b0, 8'hFF, 1);
        add(8'h00, 1'b0, 8'hFF, 1);
        add(8'h04, 1'b0, 8'hFF, 2);
        add(8'h00, 1'b0, 8'hFF, 1);
        add(8'h04, 1'b0, 8'hFF, 6);
        add(8'h04, 1'b0, 8'hFB, 1);
        add(8'h04, 1'b0, 8'hFB, 2);
        add(8'h04, 1'b1, 8'hFF, 1);
        add(8'h00, 1'b0, 8'hFF, 8);
        // Clear/set collision: latch key 0, then key 5 rises on a clear edge.
        add(8'h01, 1'b0, 8'hFF, 6);
        add(8'h01, 1'b0, 8'hFE, 1);
        add(8'h20, 1'b0, 8'hFE, 6);
        add(8'h20, 1'b1, 8'hDF, 1);
        add(8'h20, 1'b0, 8'hDF, 2);
        add(8'h20, 1'b1, 8'hFF, 1);
        add(8'h00, 1'b0, 8'hFF, 8);
        // Held key across clear: key 7 stays cleared while held, relatches
        // only after release and a fresh press.
        add(8'h80, 1'b0, 8'hFF, 6);
        add(8'h80, 1'b0, 8'h7F, 4);
        add(8'h80, 1'b1, 8'hFF, 1);
        add(8'h80, 1'b0, 8'hFF, 8);
        add(8'h00, 1'b0, 8'hFF, 8);
        add(8'h80, 1'b0, 8'hFF, 6);
        add(8'h80, 1'b0, 8'h7F, 2);
        add(8'h80, 1'b1, 8'hFF, 1);
        add(8'h00, 1'b0, 8'hFF, 8);

        // ---------------- reset held with all keys pressed
        iRst_n = 1'b1;
        iKey   = 8'hFF;
        iClr   = 1'b0;
        #1;
        iRst_n = 1'b0;
        #1;
        check("rst_initial", 8'hFF);
        for (int i = 0; i < 10; i++) cyc(8'hFF, 1'b0, 8'hFF, "rst_hold");

        // Release with keys still high: all latch at edge 7.
        iRst_n = 1'b1;
        for (int i = 0; i < 6; i++) cyc(8'hFF, 1'b0, 8'hFF, "rst_rel_wait");
        cyc(8'hFF, 1'b0, 8'h00, "rst_rel_all");
        cyc(8'hFF, 1'b1, 8'hFF, "rst_rel_clr");
        for (int i = 0; i < 8; i++) cyc(8'h00, 1'b0, 8'hFF, "rst_rel_idle");

        // ---------------- table
        foreach (vecs[i]) cyc(vecs[i].key, vecs[i].clr, vecs[i].exp, $sformatf("vec%0d", i));

        // ---------------- asynchronous reset mid-debounce
        for (int i = 0; i < 6; i++) cyc(8'h02, 1'b0, 8'hFF, "ar_k1_wait");
        cyc(8'h02, 1'b0, 8'hFD, "ar_k1_lat");
        for (int i = 0; i < 4; i++) cyc(8'h10, 1'b0, 8'hFD, "ar_k4_cnt");
        #2;
        iRst_n = 1'b0;
        #1;
        check("ar_immediate", 8'hFF);
        cyc(8'h10, 1'b0, 8'hFF, "ar_in_rst");
        cyc(8'h10, 1'b0, 8'hFF, "ar_in_rst");
        iRst_n = 1'b1;
        for (int i = 0; i < 6; i++) cyc(8'h10, 1'b0, 8'hFF, "ar_rel_wait");
        cyc(8'h10, 1'b0, 8'hEF, "ar_rel_lat");

        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain left %0d want 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
